// File: rtl/mem_dump_ctrl.sv
// mem_dump_ctrl: memory-dump sequencer that walks an inclusive address range,
// reading each word through the memory port shared with the CPU and handing
// address/data pairs to the display logic over a valid/ready handshake.
// The CPU has priority on the port, but the dump gets one port cycle after
// STARVE consecutive CPU-held cycles in REQ.
// Optional feature macro: MEM_DUMP_AUTO_EN (honour auto_mode in HOLD).
module mem_dump_ctrl #(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 16,
    parameter int unsigned STARVE = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          step,
    input  logic          auto_mode,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] last_addr,
    input  logic          cpu_req,
    output logic          cpu_grant,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_data,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StPresent, StHold} state_e;

    localparam logic [7:0] StarveMax = 8'(STARVE);

    state_e        state_q;
    logic [AW-1:0] cur_addr_q;
    logic [AW-1:0] end_addr_q;
    logic [7:0]    starve_cnt_q;
    logic [AW-1:0] dump_addr_q;
    logic [DW-1:0] dump_data_q;
    logic          dump_valid_q;
    logic          done_q;

    logic          cpu_wins;
    logic          advance;

`ifdef MEM_DUMP_AUTO_EN
    assign advance = step | auto_mode;
`else
    logic unused_auto_mode;
    assign unused_auto_mode = auto_mode;
    assign advance          = step;
`endif

    // Port arbitration: CPU keeps the port unless it has already starved the dump.
    always_comb begin
        cpu_wins  = cpu_req && (starve_cnt_q < StarveMax);
        mem_rd    = (state_q == StReq) && !cpu_wins;
        cpu_grant = cpu_req && !mem_rd;
    end

    assign mem_addr   = cur_addr_q;
    assign dump_addr  = dump_addr_q;
    assign dump_data  = dump_data_q;
    assign dump_valid = dump_valid_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;

    // Dump sequencer; abort overrides every transition out of a busy state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cur_addr_q   <= '0;
            end_addr_q   <= '0;
            starve_cnt_q <= '0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != StIdle)) begin
                state_q      <= StIdle;
                dump_valid_q <= 1'b0;
                done_q       <= 1'b1;
            end else begin
                case (state_q)
                    StIdle: begin
                        // A simultaneous abort suppresses the start.
                        if (start && !abort) begin
                            cur_addr_q   <= base_addr;
                            end_addr_q   <= last_addr;
                            starve_cnt_q <= '0;
                            state_q      <= StReq;
                        end
                    end
                    StReq: begin
                        if (mem_rd) begin
                            starve_cnt_q <= '0;
                            state_q      <= StWait;
                        end else begin
                            starve_cnt_q <= starve_cnt_q + 8'd1;
                        end
                    end
                    StWait: begin
                        dump_data_q  <= mem_rdata;
                        dump_addr_q  <= cur_addr_q;
                        dump_valid_q <= 1'b1;
                        state_q      <= StPresent;
                    end
                    StPresent: begin
                        if (dump_ready) begin
                            dump_valid_q <= 1'b0;
                            if (cur_addr_q == end_addr_q) begin
                                done_q  <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                // Natural wrap from all-ones to zero.
                                cur_addr_q <= cur_addr_q + AW'(1);
                                state_q    <= StHold;
                            end
                        end
                    end
                    StHold: begin
                        if (advance) begin
                            state_q <= StReq;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Self-checking bench for mem_dump_ctrl: a word-count based reference model
// checked every cycle, directed scenarios with literal expectations, and a
// randomized soak.
`timescale 1ns/1ps
module tb_mem_dump_ctrl;

    localparam int unsigned AW     = 16;
    localparam int unsigned DW     = 16;
    localparam int unsigned STARVE = 4;

    localparam int PH_IDLE = 0;
    localparam int PH_ASK  = 1;
    localparam int PH_READ = 2;
    localparam int PH_SHOW = 3;
    localparam int PH_GAP  = 4;

`ifdef MEM_DUMP_AUTO_EN
    localparam bit AutoEn = 1'b1;
`else
    localparam bit AutoEn = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          start      = 1'b0;
    logic          abort      = 1'b0;
    logic          step       = 1'b0;
    logic          auto_mode  = 1'b0;
    logic [AW-1:0] base_addr  = '0;
    logic [AW-1:0] last_addr  = '0;
    logic          cpu_req    = 1'b0;
    logic          dump_ready = 1'b0;
    logic [DW-1:0] mem_rdata  = '0;
    logic          cpu_grant;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;
    logic          dump_valid;
    logic          busy;
    logic          done;

    mem_dump_ctrl #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .step       (step),
        .auto_mode  (auto_mode),
        .base_addr  (base_addr),
        .last_addr  (last_addr),
        .cpu_req    (cpu_req),
        .cpu_grant  (cpu_grant),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [15:0] salt = '0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a ^ salt) + 16'h0100;
    endfunction

    // Synchronous memory: data for the strobed address appears next cycle.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_word(mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining-word count and next address per dump.
    int          m_phase     = PH_IDLE;
    int          m_left      = 0;
    int          m_starve    = 0;
    logic [15:0] m_next      = '0;
    logic [15:0] m_rdaddr    = '0;
    logic [15:0] m_show_addr = '0;
    logic [15:0] m_show_data = '0;
    logic        m_valid     = 1'b0;
    logic        m_done      = 1'b0;

    task automatic model_reset();
        m_phase = PH_IDLE; m_left = 0; m_starve = 0; m_next = '0; m_rdaddr = '0;
        m_show_addr = '0; m_show_data = '0; m_valid = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_step(input logic rd);
        logic        nd;
        logic [15:0] cnt16;
        nd = 1'b0;
        if (abort && m_phase != PH_IDLE) begin
            m_phase = PH_IDLE;
            m_valid = 1'b0;
            nd      = 1'b1;
        end else begin
            case (m_phase)
                PH_IDLE: if (start && !abort) begin
                    cnt16    = last_addr - base_addr + 16'd1;
                    m_left   = (cnt16 == 16'd0) ? 65536 : int'(cnt16);
                    m_next   = base_addr;
                    m_starve = 0;
                    m_phase  = PH_ASK;
                end
                PH_ASK: if (rd) begin
                    m_starve = 0;
                    m_rdaddr = m_next;
                    m_phase  = PH_READ;
                end else begin
                    m_starve++;
                end
                PH_READ: begin
                    m_show_addr = m_rdaddr;
                    m_show_data = mem_word(m_rdaddr);
                    m_valid     = 1'b1;
                    m_phase     = PH_SHOW;
                end
                PH_SHOW: if (dump_ready) begin
                    m_valid = 1'b0;
                    m_left--;
                    if (m_left == 0) begin
                        nd      = 1'b1;
                        m_phase = PH_IDLE;
                    end else begin
                        m_next  = m_next + 16'd1;
                        m_phase = PH_GAP;
                    end
                end
                PH_GAP: if (step || (AutoEn && auto_mode)) m_phase = PH_ASK;
                default: m_phase = PH_IDLE;
            endcase
        end
        m_done = nd;
    endtask

    // Observation logs used by the directed literal checks.
    int          cyc      = 0;
    int          trig_cyc = 0;
    int          hs_cyc   = -1;
    int          done_cnt = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] acc_addr[$];
    logic [15:0] acc_data[$];
    int          rd_lat[$];
    int          val_lat[$];
    int          hs_gap[$];

    // Compare DUT against the model once per cycle, then advance the model.
    always begin : compare
        logic exp_rd;
        logic exp_grant;
        @(negedge clk);
        cyc++;
        if (reset) model_reset();
        exp_rd    = (m_phase == PH_ASK) && !(cpu_req && (m_starve < int'(STARVE)));
        exp_grant = cpu_req && !exp_rd;
        chk("mem_rd", 32'(mem_rd), 32'(exp_rd));
        chk("cpu_grant", 32'(cpu_grant), 32'(exp_grant));
        chk("busy", 32'(busy), 32'(m_phase != PH_IDLE));
        chk("dump_valid", 32'(dump_valid), 32'(m_valid));
        chk("done", 32'(done), 32'(m_done));
        if (exp_rd) chk("mem_addr", 32'(mem_addr), 32'(m_next));
        if (m_valid) begin
            chk("dump_addr", 32'(dump_addr), 32'(m_show_addr));
            chk("dump_data", 32'(dump_data), 32'(m_show_data));
        end
        if (done === 1'b1) done_cnt++;
        if (mem_rd === 1'b1) begin
            rd_lat.push_back(cyc - trig_cyc);
            if (hs_cyc >= 0) hs_gap.push_back(cyc - hs_cyc);
            hs_cyc = -1;
        end
        if (dump_valid === 1'b1 && prev_valid !== 1'b1) val_lat.push_back(cyc - trig_cyc);
        if (dump_valid === 1'b1 && dump_ready) begin
            acc_addr.push_back(dump_addr);
            acc_data.push_back(dump_data);
            hs_cyc = cyc;
        end
        if (!reset && start && !busy && !abort) begin
            trig_cyc = cyc;
            hs_cyc   = -1;
        end else if (!reset && step) begin
            trig_cyc = cyc;
        end
        prev_valid = reset ? 1'b0 : dump_valid;
        if (!reset) model_step(exp_rd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_addr.delete(); acc_data.delete(); rd_lat.delete(); val_lat.delete();
        hs_gap.delete(); hs_cyc = -1;
    endtask

    task automatic pulse_start(input logic [15:0] b, input logic [15:0] l);
        base_addr = b;
        last_addr = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic run_to_idle(input string tag, input int budget, input bit steps);
        int n;
        n = 0;
        while (m_phase != PH_IDLE && n < budget) begin
            step = steps && (m_phase == PH_GAP);
            tick();
            n++;
        end
        step = 1'b0;
        tick();
        chk({tag, ".idle"}, 32'(busy), 32'(0));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".cpu_grant"}, 32'(cpu_grant), 32'(0));
        chk({tag, ".mem_rd"}, 32'(mem_rd), 32'(0));
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(0));
        chk({tag, ".dump_addr"}, 32'(dump_addr), 32'(0));
        chk({tag, ".dump_data"}, 32'(dump_data), 32'(0));
        chk({tag, ".dump_valid"}, 32'(dump_valid), 32'(0));
        chk({tag, ".busy"}, 32'(busy), 32'(0));
        chk({tag, ".done"}, 32'(done), 32'(0));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        int d0;
        int n;
        logic [15:0] a0;
        logic [15:0] dd0;
        logic [15:0] wrap_a[4];
        logic [15:0] wrap_d[4];

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        tick();

        // Manual walk 0x0010..0x0012, memory = addr + 0x100.
        clear_logs();
        salt = 16'h0000; dump_ready = 1'b1; auto_mode = 1'b0; cpu_req = 1'b0;
        d0 = done_cnt;
        pulse_start(16'h0010, 16'h0012);
        run_to_idle("manual", 100, 1'b1);
        chk("manual.count", 32'(acc_addr.size()), 32'(3));
        for (int i = 0; i < 3; i++) begin
            chk("manual.addr", 32'(acc_addr[i]), 32'(16'h0010 + i));
            chk("manual.data", 32'(acc_data[i]), 32'(16'h0110 + i));
            chk("manual.rd_latency", 32'(rd_lat[i]), 32'(1));
            chk("manual.valid_latency", 32'(val_lat[i]), 32'(3));
        end
        chk("manual.done_pulses", 32'(done_cnt - d0), 32'(1));

        // Wrap FFFE..0001; auto mode when the feature is built in.
        clear_logs();
        auto_mode = 1'b1;
        wrap_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        wrap_d = '{16'h00FE, 16'h00FF, 16'h0100, 16'h0101};
        pulse_start(16'hFFFE, 16'h0001);
        run_to_idle("wrap", 100, !AutoEn);
        chk("wrap.count", 32'(acc_addr.size()), 32'(4));
        for (int i = 0; i < 4; i++) begin
            chk("wrap.addr", 32'(acc_addr[i]), 32'(wrap_a[i]));
            chk("wrap.data", 32'(acc_data[i]), 32'(wrap_d[i]));
        end
        chk("wrap.gaps", 32'(hs_gap.size()), 32'(3));
        if (AutoEn) begin
            for (int i = 0; i < 3; i++) chk("wrap.auto_gap", 32'(hs_gap[i]), 32'(2));
        end
        auto_mode = 1'b0;

        // Contention: CPU holds the port throughout.
        clear_logs();
        cpu_req = 1'b1;
        pulse_start(16'h0020, 16'h0021);
        run_to_idle("contend", 200, 1'b1);
        cpu_req = 1'b0;
        chk("contend.reads", 32'(rd_lat.size()), 32'(2));
        for (int i = 0; i < 2; i++) chk("contend.rd_latency", 32'(rd_lat[i]), 32'(STARVE + 1));

        // Backpressure: ready low for 10 cycles while presenting.
        clear_logs();
        dump_ready = 1'b0;
        pulse_start(16'h0040, 16'h0041);
        n = 0;
        while (dump_valid !== 1'b1 && n < 20) begin tick(); n++; end
        chk("bp.valid", 32'(dump_valid), 32'(1));
        a0 = dump_addr; dd0 = dump_data;
        chk("bp.first_addr", 32'(a0), 32'(16'h0040));
        chk("bp.first_data", 32'(dd0), 32'(16'h0140));
        repeat (10) begin
            tick();
            chk("bp.hold_addr", 32'(dump_addr), 32'(a0));
            chk("bp.hold_data", 32'(dump_data), 32'(dd0));
            chk("bp.hold_valid", 32'(dump_valid), 32'(1));
        end
        dump_ready = 1'b1;
        run_to_idle("bp", 100, 1'b1);
        chk("bp.reads", 32'(rd_lat.size()), 32'(2));
        chk("bp.words", 32'(acc_addr.size()), 32'(2));

        // Abort in WAIT.
        clear_logs();
        d0 = done_cnt;
        pulse_start(16'h0050, 16'h0053);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_wait.busy", 32'(busy), 32'(0));
        chk("abort_wait.done", 32'(done), 32'(1));
        chk("abort_wait.valid", 32'(dump_valid), 32'(0));
        repeat (2) tick();
        chk("abort_wait.done_pulses", 32'(done_cnt - d0), 32'(1));
        chk("abort_wait.reads", 32'(rd_lat.size()), 32'(1));

        // Start and abort together while presenting.
        dump_ready = 1'b0;
        pulse_start(16'h0060, 16'h0062);
        n = 0;
        while (dump_valid !== 1'b1 && n < 20) begin tick(); n++; end
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_pres.busy", 32'(busy), 32'(0));
        chk("abort_pres.done", 32'(done), 32'(1));
        chk("abort_pres.valid", 32'(dump_valid), 32'(0));
        repeat (3) tick();
        chk("abort_pres.no_restart", 32'(busy), 32'(0));
        chk("abort_pres.done_pulses", 32'(done_cnt - d0), 32'(2));
        dump_ready = 1'b1;

        // Asynchronous reset while waiting in HOLD.
        clear_logs();
        pulse_start(16'h0080, 16'h0082);
        n = 0;
        while (m_phase != PH_GAP && n < 30) begin tick(); n++; end
        chk("hold_rst.in_hold_busy", 32'(busy), 32'(1));
        chk("hold_rst.in_hold_valid", 32'(dump_valid), 32'(0));
        d0 = done_cnt;
        #1 reset = 1'b1;
        #1 check_zero("hold_rst");
        tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("hold_rst.no_done", 32'(done_cnt - d0), 32'(0));
        clear_logs();
        pulse_start(16'h0080, 16'h0082);
        run_to_idle("after_rst", 100, 1'b1);
        chk("after_rst.count", 32'(acc_addr.size()), 32'(3));
        for (int i = 0; i < 3; i++) begin
            chk("after_rst.addr", 32'(acc_addr[i]), 32'(16'h0080 + i));
            chk("after_rst.data", 32'(acc_data[i]), 32'(16'h0180 + i));
        end

        // Randomized soak against the model.
        salt = 16'($urandom);
        for (int c = 0; c < 4000; c++) begin
            cpu_req    = 1'($urandom % 2);
            dump_ready = (($urandom % 4) != 0);
            step       = (($urandom % 3) == 0);
            abort      = (($urandom % 80) == 0);
            start      = !abort && (($urandom % 6) == 0);
            if (start) begin
                base_addr = 16'($urandom);
                last_addr = base_addr + 16'($urandom_range(0, 5));
                auto_mode = 1'($urandom % 2);
            end
            tick();
        end
        start = 1'b0; abort = 1'b0; step = 1'b0; cpu_req = 1'b0; dump_ready = 1'b1;
        run_to_idle("random", 2000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_dump_ctrl.md
# mem_dump_ctrl

Sequencer and port arbiter for the memory-dump path of the lab processor. On a start pulse it walks a programmable address range, reading each word through the single memory read port it shares with the CPU, and presents each address/data pair to the display logic over a valid/ready handshake. The CPU has priority on the port, subject to a bounded-starvation guard. Advancing between words is either manual (step pulse) or automatic.

## Interface
- AW, 16, address width
- DW, 16, data width
- STARVE, 8, consecutive CPU-held cycles after which the dump is granted one port cycle (range 1–255)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; begin dump at base_addr
- abort  in  1  one-cycle pulse; terminate dump
- step  in  1  one-cycle pulse; advance to next word (manual mode)
- auto_mode  in  1  1 = advance automatically after each accepted word (only with MEM_DUMP_AUTO_EN)
- base_addr  in  AW  first address; sampled on start
- last_addr  in  AW  final address inclusive; sampled on start
- cpu_req  in  1  CPU requests the memory port this cycle
- cpu_grant  out  1  CPU owns the port this cycle
- mem_addr  out  AW  port address when the dump owns the port
- mem_rd  out  1  dump read strobe; mem_rdata is valid on the following cycle
- mem_rdata  in  DW  synchronous read data
- dump_addr  out  AW  address of the presented word
- dump_data  out  DW  presented word
- dump_valid  out  1  presented word valid
- dump_ready  in  1  display accepts the word
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse when the last word is accepted or an abort completes

## Operation
- States: IDLE, REQ, WAIT, PRESENT, HOLD.
- IDLE: on start, latch base_addr into cur_addr and last_addr into end_addr, clear starve_cnt, then go to REQ. Step is ignored in IDLE.
- REQ: the dump requests the port.
  - If cpu_req is high and starve_cnt < STARVE: cpu_grant=1, mem_rd=0, starve_cnt increments.
  - Otherwise: mem_rd=1, mem_addr=cur_addr, cpu_grant=0, starve_cnt clears, go to WAIT.
- WAIT: capture mem_rdata into dump_data and cur_addr into dump_addr, then go to PRESENT.
- PRESENT: dump_valid=1. Data and address are held stable until dump_ready.
  - On dump_valid & dump_ready with cur_addr == end_addr: pulse done, go to IDLE.
  - Otherwise, increment cur_addr modulo 2^AW (0xFFFF wraps to 0x0000), then go to HOLD.
- HOLD: wait for step, then go to REQ. In auto mode, go to REQ on the next cycle without waiting for step.
- Port ownership: cpu_grant = cpu_req in every state except the REQ cycle that issues mem_rd.
- Range rules:
  - base == last: exactly one word is dumped.
  - last < base: the walk wraps through 0xFFFF to 0x0000.
  - Word count is (last − base + 1) mod 2^AW; a count of 0 denotes a full 2^AW-word sweep.
- Abort, in any non-IDLE state: go to IDLE next cycle, drop dump_valid, pulse done. An abort in IDLE is ignored.
- Start while busy is ignored.
- Abort and start in the same cycle: abort wins, and start is not queued.
- Step pulses outside HOLD are dropped, not queued.
- busy = (state != IDLE).

## Timing
- Reset values: state=IDLE; cpu_grant=0; mem_rd=0; mem_addr=0; dump_addr=0; dump_data=0; dump_valid=0; busy=0; done=0; all internal counters 0.
- Reset mid-dump takes effect immediately; no done pulse is generated.
- Latency, uncontended, with start at cycle 0:
  - REQ at cycle 1 (mem_rd=1)
  - WAIT at cycle 2
  - dump_valid=1 at cycle 3
- dump_valid & dump_ready at cycle N puts the state in HOLD at N+1. In auto mode, the next mem_rd is at N+2.
- Starvation bound: at most STARVE consecutive cycles of CPU grant while the dump sits in REQ. The port is then granted to the dump for exactly one cycle.
- done is registered and asserts the cycle after the final handshake or abort.
- All outputs are registered except cpu_grant and mem_rd, which are decoded from state and cpu_req.

## Configuration
- MEM_DUMP_AUTO_EN defined: the auto_mode input is honoured, and HOLD advances unconditionally when auto_mode=1.
- MEM_DUMP_AUTO_EN undefined: auto_mode is ignored, and HOLD always waits for step. All other behaviour is identical.

## Test plan
- Manual walk, base=0x0010, last=0x0012, memory holds address+0x100, dump_ready tied high, one step per HOLD: three words presented (0x0010/0x0110 … 0x0012/0x0112); done pulses once; busy falls.
- Wrap, base=0xFFFE, last=0x0001, auto_mode=1 (macro defined): four words, addresses FFFE, FFFF, 0000, 0001 in order; no step required.
- Contention, STARVE=4, cpu_req held high from start: cpu_grant high for 4 REQ cycles, then low for one cycle with mem_rd=1, repeating per word.
- Backpressure, dump_ready low for 10 cycles during PRESENT: dump_addr and dump_data stable throughout; word accepted on the ready cycle; no duplicate read.
- Abort in WAIT, then start and abort in the same cycle from PRESENT: IDLE next cycle, dump_valid=0, done pulses once each time, busy=0, no restart.
- Asynchronous reset asserted mid-HOLD: all outputs zero immediately, no done pulse; a subsequent start runs a full dump normally.
